// File: rtl/lsu_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lsu_bus_master                                               |
// | Description : Load/store unit bus master for the M pipeline stage.         |
// |               Latches a load/store request, stalls the pipeline, issues a  |
// |               single-beat command on the data bus and returns an aligned,  |
// |               sign/zero-extended load result with a one-cycle pulse.       |
// |               A wait counter abandons an access that is never acked.       |
// | Optional    : LSU_MISALIGN_TRAP_EN - when defined, misaligned half/word    |
// |               accesses skip the bus and complete with an addr_err pulse.   |
// |               When undefined, the low address bits are ignored as needed.  |
// | Ports       : clk, clr_n (sync active-low reset)                           |
// |               req_valid/req_we/req_size/req_signed/req_addr/req_wdata  in  |
// |               stall, rdata, rdata_valid, addr_err, bus_err             out |
// |               mem_req/mem_we/mem_addr/mem_be/mem_wdata                 out |
// |               mem_ack, mem_rdata                                       in  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lsu_bus_master (
    input  logic        clk,
    input  logic        clr_n,
    // request from the M stage
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    // pipeline side results
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        addr_err,
    output logic        bus_err,
    // data memory bus
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUS  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;

    // The counter is compared against one below the limit so that the access
    // is abandoned on the cycle the count reaches 255, i.e. after exactly
    // 255 bus cycles without an acknowledge.
    localparam logic [7:0] c_WAIT_LAST = 8'd254;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [7:0]  r_wait;
    logic        r_timeout;
    logic [31:0] r_rdata;

    logic        w_timeout;
    logic        w_req_misal;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_lb;
    logic [15:0] w_lh;
    logic [31:0] w_load_data;

`ifdef LSU_MISALIGN_TRAP_EN
    logic        r_misal;

    // Half needs addr[0]=0; word (size 10 or 11) needs addr[1:0]=0.
    assign w_req_misal = ((req_size == c_SZ_HALF) && req_addr[0]) ||
                         (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign w_req_misal = 1'b0;
`endif

    assign w_timeout = (r_state == c_ST_BUS) && !mem_ack && (r_wait == c_WAIT_LAST);

    // ------------------------------------------------------------------
    // Store byte enables and lane replication
    // ------------------------------------------------------------------
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
        case (r_size)
            c_SZ_BYTE: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            c_SZ_HALF: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_wdata;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load lane selection and extension
    // ------------------------------------------------------------------
    always_comb begin
        w_lb = mem_rdata[7:0];
        case (r_addr[1:0])
            2'd0:    w_lb = mem_rdata[7:0];
            2'd1:    w_lb = mem_rdata[15:8];
            2'd2:    w_lb = mem_rdata[23:16];
            default: w_lb = mem_rdata[31:24];
        endcase
        w_lh = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        w_load_data = mem_rdata;
        case (r_size)
            c_SZ_BYTE: w_load_data = {{24{r_signed & w_lb[7]}}, w_lb};
            c_SZ_HALF: w_load_data = {{16{r_signed & w_lh[15]}}, w_lh};
            default:   w_load_data = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        mem_req     = 1'b0;
        rdata_valid = 1'b0;
        bus_err     = 1'b0;
        addr_err    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    w_state_nxt = w_req_misal ? c_ST_DONE : c_ST_BUS;
                end
            end
            c_ST_BUS: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ack || w_timeout) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                // req_valid is still the completing instruction here.
                rdata_valid = 1'b1;
                bus_err     = r_timeout;
`ifdef LSU_MISALIGN_TRAP_EN
                addr_err    = r_misal;
`endif
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, wait counter and load result
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_we      <= 1'b0;
            r_size    <= 2'b00;
            r_signed  <= 1'b0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_wait    <= 8'h0;
            r_timeout <= 1'b0;
            r_rdata   <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_misal   <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_wait    <= 8'h0;
                    r_timeout <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    r_misal   <= req_valid & w_req_misal;
`endif
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                    end
                end
                c_ST_BUS: begin
                    if (mem_ack) begin
                        // Stores keep the previous load result.
                        if (!r_we) begin
                            r_rdata <= w_load_data;
                        end
                    end else if (w_timeout) begin
                        r_timeout <= 1'b1;
                        r_rdata   <= 32'h0;
                        r_wait    <= r_wait + 8'd1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                default: begin
                    r_wait <= 8'h0;
                end
            endcase
        end
    end

    assign rdata     = r_rdata;
    assign mem_we    = r_we;
    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign mem_be    = w_be;
    assign mem_wdata = w_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lsu_bus_master                                            |
// | Description : Directed self-checking bench for lsu_bus_master. Each access |
// |               is driven through one task that models the memory (ack on a |
// |               chosen bus cycle) and records what the DUT did; expected     |
// |               values are hand-computed constants.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lsu_bus_master;

    logic        clk;
    logic        clr_n;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        addr_err;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks;
    int n_fails;

    // results recorded by run_access
    int          t_stall;
    int          t_req;
    int          t_vcyc;
    logic        t_stable;
    logic        t_we;
    logic [31:0] t_addr;
    logic [3:0]  t_be;
    logic [31:0] t_wdata;
    logic [31:0] t_rdata;
    logic        t_berr;
    logic        t_aerr;

    lsu_bus_master u_dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .addr_err    (addr_err),
        .bus_err     (bus_err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Entered at posedge+1; drives the request, then per cycle samples the
    // DUT, plays memory (ack on bus cycle ack_cycle, 0 = never) and drops
    // req_valid in the cycle after the completion pulse. Returns at posedge+1.
    task automatic run_access(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input int ack_cycle, input logic [31:0] rd_in);
        int c;
        bit done;
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        t_stall = 0; t_req = 0; t_vcyc = 0; t_stable = 1'b1;
        t_we = 1'b0; t_addr = 32'h0; t_be = 4'h0; t_wdata = 32'h0;
        t_rdata = 32'h0; t_berr = 1'b0; t_aerr = 1'b0;
        c = 0;
        done = 1'b0;
        while (!done && c < 400) begin
            c++;
            #1;
            if (stall) t_stall++;
            if (mem_req) begin
                t_req++;
                if (t_req == 1) begin
                    t_we = mem_we; t_addr = mem_addr; t_be = mem_be; t_wdata = mem_wdata;
                end else if ({mem_we, mem_addr, mem_be, mem_wdata} !== {t_we, t_addr, t_be, t_wdata}) begin
                    t_stable = 1'b0;
                end
                mem_ack   = (t_req == ack_cycle);
                mem_rdata = rd_in;
            end
            if (rdata_valid) begin
                done    = 1'b1;
                t_vcyc  = c;
                t_rdata = rdata;
                t_berr  = bus_err;
                t_aerr  = addr_err;
            end
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = 32'hDEADBEEF;
            if (done) req_valid = 1'b0;
        end
        if (!done) check_eq("access_bound", 32'd0, 32'd1);
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        clr_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1;
        clr_n = 1'b1;
        #1;
        check_eq("rst_stall",    32'(stall),       32'd0);
        check_eq("rst_mem_req",  32'(mem_req),     32'd0);
        check_eq("rst_rdata",    rdata,            32'h0);
        check_eq("rst_valid",    32'(rdata_valid), 32'd0);
        check_eq("rst_bus_err",  32'(bus_err),     32'd0);
        check_eq("rst_addr_err", 32'(addr_err),    32'd0);

        // ---------------- sw 0x12345678 @0x10, same-cycle ack ----------------
        @(posedge clk); #1;
        run_access(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, 1, 32'h0);
        check_eq("sw_be",     32'(t_be),    32'hF);
        check_eq("sw_addr",   t_addr,       32'h10);
        check_eq("sw_wdata",  t_wdata,      32'h12345678);
        check_eq("sw_we",     32'(t_we),    32'd1);
        check_eq("sw_stall",  32'(t_stall), 32'd2);
        check_eq("sw_vcyc",   32'(t_vcyc),  32'd3);
        check_eq("sw_reqcyc", 32'(t_req),   32'd1);
        check_eq("sw_rdata",  t_rdata,      32'h0);
        #1;
        // req_valid was still high in DONE; it must not have started a new access
        check_eq("sw_after_req",   32'(mem_req), 32'd0);
        check_eq("sw_after_stall", 32'(stall),   32'd0);

        // ---------------- lb / lbu @0x13 ----------------
        run_access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1, 32'h80AABBCC);
        check_eq("lb_rdata", t_rdata,   32'hFFFFFF80);
        check_eq("lb_be",    32'(t_be), 32'h8);
        check_eq("lb_addr",  t_addr,    32'h10);
        check_eq("lb_we",    32'(t_we), 32'd0);
        run_access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1, 32'h80AABBCC);
        check_eq("lbu_rdata", t_rdata, 32'h00000080);

        // ---------------- sb @0x21, sh @0x22 (rdata must be kept) ----------------
        run_access(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000EE, 1, 32'h0);
        check_eq("sb_be",    32'(t_be), 32'h2);
        check_eq("sb_wdata", t_wdata,   32'hEEEEEEEE);
        check_eq("sb_addr",  t_addr,    32'h20);
        check_eq("sb_rdata_kept", t_rdata, 32'h00000080);
        run_access(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, 1, 32'h0);
        check_eq("sh_be",    32'(t_be), 32'hC);
        check_eq("sh_wdata", t_wdata,   32'hBEEFBEEF);

        // ---------------- halfword and word loads ----------------
        run_access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1, 32'h80AABBCC);
        check_eq("lh_rdata", t_rdata,   32'hFFFF80AA);
        check_eq("lh_be",    32'(t_be), 32'hC);
        run_access(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1, 32'h80AABBCC);
        check_eq("lhu_rdata", t_rdata,   32'h0000BBCC);
        check_eq("lhu_be",    32'(t_be), 32'h3);
        run_access(1'b0, 2'b11, 1'b1, 32'h10, 32'h0, 1, 32'h80AABBCC);
        check_eq("lw11_rdata", t_rdata,   32'h80AABBCC);
        check_eq("lw11_be",    32'(t_be), 32'hF);

        // ---------------- ack on the 5th bus cycle ----------------
        run_access(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 5, 32'hCAFEF00D);
        check_eq("dly_stall",  32'(t_stall),  32'd6);
        check_eq("dly_stable", 32'(t_stable), 32'd1);
        check_eq("dly_reqcyc", 32'(t_req),    32'd5);
        check_eq("dly_rdata",  t_rdata,       32'hCAFEF00D);
        check_eq("dly_addr",   t_addr,        32'h44);

        // ---------------- no ack: timeout after 255 bus cycles ----------------
        run_access(1'b0, 2'b10, 1'b0, 32'h48, 32'h0, 0, 32'h13572468);
        check_eq("to_bus_err", 32'(t_berr),   32'd1);
        check_eq("to_rdata",   t_rdata,       32'h0);
        check_eq("to_reqcyc",  32'(t_req),    32'd255);
        check_eq("to_stall",   32'(t_stall),  32'd256);
        check_eq("to_stable",  32'(t_stable), 32'd1);
        #1;
        check_eq("to_after_bus_err", 32'(bus_err), 32'd0);
        check_eq("to_after_mem_req", 32'(mem_req), 32'd0);

        // ---------------- reset while in BUS ----------------
        run_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 32'h24681357);
        check_eq("pre_rst_rdata", t_rdata, 32'h24681357);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h30;
        @(posedge clk); #1;
        check_eq("rstbus_req_before", 32'(mem_req), 32'd1);
        clr_n = 1'b0;
        @(posedge clk); #1;
        clr_n = 1'b1;
        req_valid = 1'b0;
        #1;
        check_eq("rstbus_req_after", 32'(mem_req), 32'd0);
        check_eq("rstbus_rdata",     rdata,        32'h0);
        check_eq("rstbus_stall",     32'(stall),   32'd0);
        @(posedge clk); #1;
        check_eq("rstbus_idle_req",  32'(mem_req), 32'd0);
        run_access(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 1, 32'h11223344);
        check_eq("rstbus_next_rdata", t_rdata,      32'h00000033);
        check_eq("rstbus_next_vcyc",  32'(t_vcyc),  32'd3);

        // ---------------- misaligned lw @0x06 ----------------
        run_access(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1, 32'h55667788);
`ifdef LSU_MISALIGN_TRAP_EN
        check_eq("mis_reqcyc",   32'(t_req),   32'd0);
        check_eq("mis_addr_err", 32'(t_aerr),  32'd1);
        check_eq("mis_vcyc",     32'(t_vcyc),  32'd2);
        check_eq("mis_rdata",    t_rdata,      32'h00000033);
`else
        check_eq("mis_addr",     t_addr,       32'h04);
        check_eq("mis_be",       32'(t_be),    32'hF);
        check_eq("mis_rdata",    t_rdata,      32'h55667788);
        check_eq("mis_addr_err", 32'(t_aerr),  32'd0);
        check_eq("mis_vcyc",     32'(t_vcyc),  32'd3);
`endif

        // ---------------- mem_ack while idle is ignored ----------------
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("idle_ack_valid", 32'(rdata_valid), 32'd0);
            check_eq("idle_ack_req",   32'(mem_req),     32'd0);
        end
        mem_ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Absolute backstop so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire

// File: doc/lsu_bus_master.md
LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset; all state changes occur on the rising edge of clk.
REQ-002 clk  in  1  pipeline clock.
REQ-003 clr_n  in  1  synchronous active-low reset.
REQ-004 req_valid  in  1  M-stage instruction is a load/store; held stable while stall=1.
REQ-005 req_we  in  1  1=store, 0=load.
REQ-006 req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-007 req_signed  in  1  load sign-extends when 1, zero-extends when 0.
REQ-008 req_addr  in  32  byte address (ALU result).
REQ-009 req_wdata  in  32  store data, forwarded register value.
REQ-010 stall  out  1  freeze IF/ID/EX/M pipeline registers.
REQ-011 rdata  out  32  aligned, extended load result.
REQ-012 rdata_valid  out  1  one-cycle completion pulse.
REQ-013 addr_err  out  1  one-cycle misalignment pulse.
REQ-014 bus_err  out  1  one-cycle timeout pulse.
REQ-015 mem_req  out  1  bus request to data memory.
REQ-016 mem_we, mem_addr[31:0], mem_be[3:0], mem_wdata[31:0]  out  bus command; mem_addr = {req_addr[31:2],2'b00}.
REQ-017 mem_ack  in  1  memory accepted the command; mem_rdata valid in the same cycle for loads.
REQ-018 mem_rdata  in  32  word read from memory.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, BUS, DONE.
REQ-020 In IDLE, stall SHALL equal req_valid combinationally; when req_valid=1, all req_* fields are latched and the next state is BUS.
REQ-021 In BUS, mem_req=1 and all mem_* outputs come from latched fields and remain stable until mem_ack is sampled 1.
REQ-022 In BUS with mem_ack=1, loads latch the extracted mem_rdata into rdata; the next state is DONE in both the load and store cases.
REQ-023 In DONE, stall=0 and rdata_valid=1 for exactly one cycle, then the FSM returns to IDLE; req_valid seen in DONE is ignored, because it belongs to the completing instruction.
REQ-024 Minimum latency SHALL be 3 cycles with 2 stalled cycles: request in IDLE, mem_req with same-cycle ack in BUS, pulse in DONE.
REQ-025 mem_be SHALL be 1<<addr[1:0] for byte, 4'b0011 or 4'b1100 by addr[1] for half, and 4'b1111 for word.
REQ-026 mem_wdata SHALL be {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for half, and wdata for word.
REQ-027 A load SHALL select byte lane addr[1:0] or halfword lane addr[1] from mem_rdata and extend per req_signed; word loads pass through unchanged.
REQ-028 An 8-bit wait counter SHALL count cycles in BUS; if it reaches 255 without mem_ack, the FSM drops mem_req, forces rdata=0, pulses bus_err in DONE and goes to DONE.
REQ-029 mem_ack outside BUS SHALL be ignored.
REQ-030 Store completion SHALL leave rdata unchanged.

Reset
REQ-031 When clr_n=0 at a clock edge: state=IDLE, wait counter=0, rdata=0, latched fields=0; from the next cycle mem_req, rdata_valid, addr_err and bus_err are 0.
REQ-032 A reset asserted in BUS SHALL abandon the access with no retry; mem_req is 0 from the cycle after the reset edge.

Configuration
REQ-033 With LSU_MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL go IDLE->DONE without mem_req, pulse addr_err with rdata_valid, and leave memory and rdata untouched.
REQ-034 Without LSU_MISALIGN_TRAP_EN, addr_err SHALL be tied to 0; misaligned low address bits are ignored (half uses addr[1], word uses lane 0) and the access proceeds normally.

Verification
REQ-035 sw wdata=0x12345678 addr=0x10, ack same cycle -> mem_be=1111, mem_addr=0x10, stall high for 2 cycles, rdata_valid pulse in the 3rd cycle.
REQ-036 lb signed addr=0x13, mem_rdata=0x80AABBCC -> rdata=0xFFFFFF80; same access with lbu -> rdata=0x00000080.
REQ-037 sb wdata=0x000000EE addr=0x21 -> mem_be=0010, mem_wdata=0xEEEEEEEE; sh addr=0x22 -> mem_be=1100.
REQ-038 ack delayed 5 cycles -> mem_* stable throughout and stall held for 6 cycles; no ack for 255 cycles -> bus_err pulse, rdata=0, return to IDLE.
REQ-039 clr_n low for 1 cycle in BUS -> mem_req=0 on the next cycle, and a subsequent load completes normally.
REQ-040 lw addr=0x06 with LSU_MISALIGN_TRAP_EN -> no mem_req, addr_err with rdata_valid in the 2nd cycle; without the macro -> mem_addr=0x04 and normal load.
